fc_layer_seq: RTL



---
 rtl/fc_pkg.sv | 41 ++++
 rtl/fc_requant.sv | 58 +++++
 rtl/fc_layer_seq.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/fc_pkg.sv
// Shared types and helpers for the sequential fully connected layer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fc_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_REQ  = 2'd2,
        S_OUT  = 2'd3
    } fc_state_t;

    // Saturation bounds for the default 8-bit activation width.
    localparam int FC_ACTIV_BITS_DEFAULT = 8;
    localparam int FC_ACT_MAX_DEFAULT    = 127;
    localparam int FC_ACT_MIN_DEFAULT    = -128;

    // Ceiling log2. Never returns less than 1 so that counters and
    // address fields always have at least one bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

    // Largest and smallest representable signed value of a given width.
    function automatic int act_max(input int bits);
        return (1 << (bits - 1)) - 1;
    endfunction

    function automatic int act_min(input int bits);
        return -(1 << (bits - 1));
    endfunction

endpackage

// File: rtl/fc_requant.sv
// Requantiser: bias add, round-half-up arithmetic shift, optional ReLU (FC_RELU_EN), saturation.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   acc  - signed lane accumulator (ACC_BITS)
//   bias - signed neuron bias (ACC_BITS)
//   q    - signed saturated activation (ACTIV_BITS)
module fc_requant
    import fc_pkg::*;
#(
    parameter int ACC_BITS   = 24,
    parameter int ACTIV_BITS = 8,
    parameter int SHIFT      = 7
) (
    input  logic signed [ACC_BITS-1:0]   acc,
    input  logic signed [ACC_BITS-1:0]   bias,
    output logic signed [ACTIV_BITS-1:0] q
);

    // Two guard bits so neither the bias add nor the rounding add can wrap
    // before saturation sees the value.
    localparam int XW = ACC_BITS + 2;
    localparam logic signed [XW-1:0] SAT_HI = XW'(act_max(ACTIV_BITS));
    localparam logic signed [XW-1:0] SAT_LO = XW'(act_min(ACTIV_BITS));

    logic signed [XW-1:0] sum;
    logic signed [XW-1:0] shifted;
    logic signed [XW-1:0] clipped;

    assign sum = XW'(acc) + XW'(bias);

    if (SHIFT > 0) begin : g_round
        localparam logic signed [XW-1:0] HALF = XW'(1) << (SHIFT - 1);
        logic signed [XW-1:0] rounded;
        assign rounded = sum + HALF;
        assign shifted = rounded >>> SHIFT;
    end else begin : g_noround
        assign shifted = sum;
    end

`ifdef FC_RELU_EN
    assign clipped = shifted[XW-1] ? '0 : shifted;
`else
    assign clipped = shifted;
`endif

    always_comb begin
        if (clipped > SAT_HI) begin
            q = SAT_HI[ACTIV_BITS-1:0];
        end else if (clipped < SAT_LO) begin
            q = SAT_LO[ACTIV_BITS-1:0];
        end else begin
            q = clipped[ACTIV_BITS-1:0];
        end
    end

endmodule

// File: rtl/fc_layer_seq.sv
// Time-multiplexed fully connected layer: LANES MAC lanes sweep G=OUTPUT_SIZE/LANES neuron groups.
// Latency: G*(INPUT_SIZE+1) cycles from input handshake to out_valid.
// Backpressure: in_ready only in IDLE; result held stable in OUT until out_ready.
//
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   in_data/valid/ready   - input vector, element i at [i*ACTIV_BITS +: ACTIV_BITS]
//   out_data/valid/ready  - result vector, same packing
//   w_wr_*                - weight write port, address o*INPUT_SIZE+i, accepted only in IDLE
//   b_wr_*                - bias write port, neuron index, accepted only in IDLE
//   busy                  - high in every state except IDLE
//   wr_drop               - one-cycle pulse after a discarded weight/bias write
// Build option: define FC_RELU_EN to clamp negative results to zero.
module fc_layer_seq
    import fc_pkg::*;
#(
    parameter int INPUT_SIZE  = 64,
    parameter int OUTPUT_SIZE = 16,
    parameter int LANES       = 4,
    parameter int ACTIV_BITS  = 8,
    parameter int WEIGHT_BITS = 8,
    parameter int ACC_BITS    = 24,
    parameter int SHIFT       = 7
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [INPUT_SIZE*ACTIV_BITS-1:0]        in_data,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    output logic [OUTPUT_SIZE*ACTIV_BITS-1:0]       out_data,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    input  logic                                    w_wr_en,
    input  logic [clog2(OUTPUT_SIZE*INPUT_SIZE)-1:0] w_wr_addr,
    input  logic signed [WEIGHT_BITS-1:0]           w_wr_data,
    input  logic                                    b_wr_en,
    input  logic [clog2(OUTPUT_SIZE)-1:0]           b_wr_addr,
    input  logic signed [ACC_BITS-1:0]              b_wr_data,
    output logic                                    busy,
    output logic                                    wr_drop
);

    localparam int G  = OUTPUT_SIZE / LANES;
    localparam int EW = clog2(INPUT_SIZE);
    localparam int GW = clog2(G);
    localparam int DW = clog2(G * INPUT_SIZE);
    localparam int OW = clog2(OUTPUT_SIZE);
    localparam int LW = clog2(LANES);
    localparam int PW = WEIGHT_BITS + ACTIV_BITS;

    localparam logic [EW-1:0] E_LAST = EW'(INPUT_SIZE - 1);
    localparam logic [GW-1:0] G_LAST = GW'(G - 1);

    fc_state_t state;
    fc_state_t state_nxt;

    logic [EW-1:0] e_cnt;
    logic [GW-1:0] g_cnt;

    logic [INPUT_SIZE-1:0][ACTIV_BITS-1:0]  in_reg;
    logic [OUTPUT_SIZE-1:0][ACTIV_BITS-1:0] out_reg;
    logic [LANES-1:0][ACTIV_BITS-1:0]       q_lane;

    logic [DW-1:0]                rd_idx;
    logic signed [ACTIV_BITS-1:0] act;

    int            w_o;
    int            w_lane;
    int            b_lane;
    logic [DW-1:0] w_idx;
    logic [GW-1:0] b_idx;
    logic          w_acc;
    logic          b_acc;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (in_valid) state_nxt = S_MAC;
            S_MAC:   if (e_cnt == E_LAST) state_nxt = S_REQ;
            S_REQ:   state_nxt = (g_cnt == G_LAST) ? S_OUT : S_MAC;
            S_OUT:   if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign out_valid = (state == S_OUT);
    assign out_data  = out_reg;

    // ------------------------------------------------------------------
    // Write decode. Neuron o lives in bank o%LANES at group o/LANES; each
    // bank stores its groups back to back, INPUT_SIZE weights per group.
    // ------------------------------------------------------------------
    always_comb begin
        w_o    = int'(w_wr_addr) / INPUT_SIZE;
        w_lane = w_o % LANES;
        w_idx  = DW'((w_o / LANES) * INPUT_SIZE + int'(w_wr_addr) % INPUT_SIZE);
        b_lane = int'(b_wr_addr) % LANES;
        b_idx  = GW'(int'(b_wr_addr) / LANES);
        w_acc  = w_wr_en && (state == S_IDLE) && (int'(w_wr_addr) < OUTPUT_SIZE * INPUT_SIZE);
        b_acc  = b_wr_en && (state == S_IDLE) && (int'(b_wr_addr) < OUTPUT_SIZE);
    end

    assign rd_idx = DW'(int'(g_cnt) * INPUT_SIZE + int'(e_cnt));
    assign act    = $signed(in_reg[e_cnt]);

    // ------------------------------------------------------------------
    // MAC lanes with their private weight and bias banks
    // ------------------------------------------------------------------
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic signed [WEIGHT_BITS-1:0] w_bank [G*INPUT_SIZE];
        logic signed [ACC_BITS-1:0]    b_bank [G];
        logic signed [WEIGHT_BITS-1:0] w_rd;
        logic signed [ACC_BITS-1:0]    b_rd;
        logic signed [ACC_BITS-1:0]    acc;
        logic signed [ACC_BITS-1:0]    acc_base;
        logic signed [PW-1:0]          prod;

        // Banks keep their contents across reset.
        always_ff @(posedge clk) begin
            if (w_acc && (w_lane == l)) begin
                w_bank[w_idx] <= w_wr_data;
            end
            if (b_acc && (b_lane == l)) begin
                b_bank[b_idx] <= b_wr_data;
            end
        end

        assign w_rd = w_bank[rd_idx];
        assign b_rd = b_bank[g_cnt];
        assign prod = PW'(w_rd) * PW'(act);

        // First element of each group restarts the sum; the add wraps.
        assign acc_base = (e_cnt == '0) ? '0 : acc;

        always_ff @(posedge clk) begin
            if (rst) begin
                acc <= '0;
            end else if (state == S_MAC) begin
                acc <= acc_base + ACC_BITS'(prod);
            end
        end

        fc_requant #(
            .ACC_BITS   (ACC_BITS),
            .ACTIV_BITS (ACTIV_BITS),
            .SHIFT      (SHIFT)
        ) u_requant (
            .acc  (acc),
            .bias (b_rd),
            .q    (q_lane[l])
        );
    end

    // ------------------------------------------------------------------
    // Counters, input capture, result register, drop pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            e_cnt   <= '0;
            g_cnt   <= '0;
            in_reg  <= '0;
            out_reg <= '0;
            wr_drop <= 1'b0;
        end else begin
            wr_drop <= (w_wr_en || b_wr_en) && (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        in_reg <= in_data;
                        e_cnt  <= '0;
                        g_cnt  <= '0;
                    end
                end
                S_MAC: begin
                    e_cnt <= (e_cnt == E_LAST) ? '0 : e_cnt + EW'(1);
                end
                S_REQ: begin
                    for (int l = 0; l < LANES; l++) begin
                        out_reg[OW'(int'(g_cnt) * LANES + l)] <= q_lane[LW'(l)];
                    end
                    g_cnt <= (g_cnt == G_LAST) ? '0 : g_cnt + GW'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule
